fetch_decode_regs: RTL

Front-end pipeline register block that acts on the stall controls issued by the load-use hazard detector (PC_Write, IF_ID_Write, block_control).
- Holds the program counter, the IF/ID pipeline register and the control field of the ID/EX register.
- Applies hold, bubble and branch-flush actions each cycle.
- Keeps saturating stall and flush performance counters for the pipeline.
- Sits between instruction memory, the decoder and the ID/EX register.

---
 rtl/fetch_decode_regs.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fetch_decode_regs.sv
// fetch_decode_regs
// Front-end pipeline register block. It holds the PC, the IF/ID register and
// the control field of the ID/EX register. Each edge it applies one of three
// actions: a branch flush, the stall controls from the load-use hazard unit,
// or a normal advance. It also keeps saturating stall and flush counters.
module fetch_decode_regs #(
   parameter int               XLEN      = 32,
   parameter logic [XLEN-1:0]  PC_RESET  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h0000_0013,
   parameter int               CTRL_W    = 8,
   parameter int               CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              PC_Write,
   input  logic              IF_ID_Write,
   input  logic              block_control,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   input  logic [31:0]       imem_instr,
   input  logic [CTRL_W-1:0] id_ctrl_in,
   input  logic              cnt_clr,
   output logic [XLEN-1:0]   pc_out,
   output logic [XLEN-1:0]   if_id_pc,
   output logic [31:0]       if_id_instr,
   output logic              if_id_valid,
   output logic [CTRL_W-1:0] id_ex_ctrl,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   logic [XLEN-1:0]   r_pc;
   logic [XLEN-1:0]   r_ifIdPc;
   logic [31:0]       r_ifIdInstr;
   logic              r_ifIdValid;
   logic [CTRL_W-1:0] r_idExCtrl;
   logic [CNT_W-1:0]  r_stallCnt;
   logic [CNT_W-1:0]  r_flushCnt;

   logic [XLEN-1:0]   w_redirectPc;
   logic [XLEN-1:0]   w_seqPc;
   logic [CTRL_W-1:0] w_ctrlQualified;
   logic              w_stallEvent;
   logic              w_stallSat;
   logic              w_flushSat;
   logic              w_unused_tgt_lsbs;

   // Branch targets are word aligned by dropping the two low bits; sequential PC wraps naturally.
   assign w_redirectPc      = {branch_target[XLEN-1:2], 2'b00};
   assign w_seqPc           = r_pc + XLEN'(4);
   assign w_unused_tgt_lsbs = ^branch_target[1:0];

   // Decoder output is meaningless for an empty IF/ID slot, so it must not leak into ID/EX.
   assign w_ctrlQualified = r_ifIdValid ? id_ctrl_in : '0;

   // A stall cycle is one where the PC is held and no flush overrides it.
   assign w_stallEvent = ~branch_taken & ~PC_Write;
   assign w_stallSat   = (r_stallCnt == {CNT_W{1'b1}});
   assign w_flushSat   = (r_flushCnt == {CNT_W{1'b1}});

   // Program counter: redirect wins, otherwise advance or hold under PC_Write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_pc <= PC_RESET;
      end else if (branch_taken) begin
         r_pc <= w_redirectPc;
      end else if (PC_Write) begin
         r_pc <= w_seqPc;
      end
   end

   // IF/ID register: flush empties it, otherwise capture the current fetch or hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ifIdPc    <= '0;
         r_ifIdInstr <= NOP_INSTR;
         r_ifIdValid <= 1'b0;
      end else if (branch_taken) begin
         r_ifIdPc    <= '0;
         r_ifIdInstr <= NOP_INSTR;
         r_ifIdValid <= 1'b0;
      end else if (IF_ID_Write) begin
         r_ifIdPc    <= r_pc;
         r_ifIdInstr <= imem_instr;
         r_ifIdValid <= 1'b1;
      end
   end

   // ID/EX control field: flush or bubble inserts zero control, otherwise pass the decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idExCtrl <= '0;
      end else if (branch_taken || block_control) begin
         r_idExCtrl <= '0;
      end else begin
         r_idExCtrl <= w_ctrlQualified;
      end
   end

   // Stall counter: saturating, with clear taking precedence over an increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stallCnt <= '0;
      end else if (cnt_clr) begin
         r_stallCnt <= '0;
      end else if (w_stallEvent && !w_stallSat) begin
         r_stallCnt <= r_stallCnt + CNT_W'(1);
      end
   end

   // Flush counter: saturating, with clear taking precedence over an increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_flushCnt <= '0;
      end else if (cnt_clr) begin
         r_flushCnt <= '0;
      end else if (branch_taken && !w_flushSat) begin
         r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
   end

   assign pc_out      = r_pc;
   assign if_id_pc    = r_ifIdPc;
   assign if_id_instr = r_ifIdInstr;
   assign if_id_valid = r_ifIdValid;
   assign id_ex_ctrl  = r_idExCtrl;
   assign stall_cnt   = r_stallCnt;
   assign flush_cnt   = r_flushCnt;

endmodule
